pe_seq_ctrl: RTL and testbench

//  Sequencer for one PE tile (6x6 MAC array, wgt_rf, pmem). Runs one convolution job on a start pulse:
//  per pass it fetches a weight row set from wmem, latches it into the weight RFs, then steps
//  i_wgt_shift through every shift position of the kernel mode, writing two psums per step into pmem.

---
 rtl/pe_seq_ctrl_if.sv | 31 +++
 rtl/pe_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_seq_ctrl_if.sv
// pe_seq_ctrl_if: sequencer-to-tile bus (wmem read, weight/bias strobes, pmem ports).
// master = sequencer, slave = PE tile datapath.
interface pe_seq_ctrl_if #(
  parameter int PMEM_ADDR_WIDTH = 8,
  parameter int WMEM_ADDR_WIDTH = 7
);
  logic [WMEM_ADDR_WIDTH-1:0] wmem_rd_addr;
  logic                       update_wgt;
  logic                       update_bias;
  logic                       bias_sel;
  logic [2:0]                 wgt_shift;
  logic                       pmem_wr_en;
  logic [PMEM_ADDR_WIDTH-1:0] pmem_wr_addr0;
  logic [PMEM_ADDR_WIDTH-1:0] pmem_wr_addr1;
  logic [PMEM_ADDR_WIDTH-1:0] pmem_rd_addr0;
  logic [PMEM_ADDR_WIDTH-1:0] pmem_rd_addr1;

  modport master (
    output wmem_rd_addr, update_wgt, update_bias, bias_sel,
    output wgt_shift, pmem_wr_en,
    output pmem_wr_addr0, pmem_wr_addr1,
    output pmem_rd_addr0, pmem_rd_addr1
  );

  modport slave (
    input wmem_rd_addr, update_wgt, update_bias, bias_sel,
    input wgt_shift, pmem_wr_en,
    input pmem_wr_addr0, pmem_wr_addr1,
    input pmem_rd_addr0, pmem_rd_addr1
  );
endinterface

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: job sequencer for one PE tile (weight load, shift steps, psum writes).
// Optional PE_SEQ_STALL_EN adds i_stall, which pauses COMPUTE.
module pe_seq_ctrl #(
  parameter int PMEM_ADDR_WIDTH = 8,
  parameter int WMEM_ADDR_WIDTH = 7,
  parameter int PASS_WIDTH      = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
`ifdef PE_SEQ_STALL_EN
  input  logic                       i_stall,
`endif
  input  logic                       i_start,
  input  logic [1:0]                 i_mode,
  input  logic [PASS_WIDTH-1:0]      i_num_pass,
  input  logic [WMEM_ADDR_WIDTH-1:0] i_wmem_base,
  input  logic [PMEM_ADDR_WIDTH-1:0] i_pmem_base,
  output logic                       o_busy,
  output logic                       o_done,
  pe_seq_ctrl_if.master              tile
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LATCH_W,
    COMPUTE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]                 step_q;
  logic [2:0]                 last_step_q;
  logic [PASS_WIDTH-1:0]      pass_q;
  logic [PASS_WIDTH-1:0]      last_pass_q;
  logic [WMEM_ADDR_WIDTH-1:0] wbase_q;
  logic [PMEM_ADDR_WIDTH-1:0] pbase_q;
  logic [WMEM_ADDR_WIDTH-1:0] wmem_addr_q;

  logic                       stall;
  logic                       step_end;
  logic                       pass_end;
  logic                       accept;
  logic [WMEM_ADDR_WIDTH-1:0] wmem_now;
  logic [PMEM_ADDR_WIDTH-1:0] addr0;
  logic [PMEM_ADDR_WIDTH-1:0] addr1;

`ifdef PE_SEQ_STALL_EN
  assign stall = i_stall;
`else
  assign stall = 1'b0;
`endif

  assign accept   = (state_q == IDLE) && i_start;
  assign step_end = (step_q == last_step_q);
  assign pass_end = (pass_q == last_pass_q);
  assign wmem_now = wbase_q + WMEM_ADDR_WIDTH'(pass_q);
  assign addr0    = pbase_q + PMEM_ADDR_WIDTH'({step_q, 1'b0});
  assign addr1    = addr0 + PMEM_ADDR_WIDTH'(1);

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // job parameters, step/pass counters, held wmem address
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_q      <= '0;
      last_step_q <= '0;
      pass_q      <= '0;
      last_pass_q <= '0;
      wbase_q     <= '0;
      pbase_q     <= '0;
      wmem_addr_q <= '0;
    end else begin
      if (accept) begin
        last_step_q <= {1'b0, i_mode} + 3'd2;
        last_pass_q <= (i_num_pass == '0) ? '0
                     : i_num_pass - PASS_WIDTH'(1);
        wbase_q     <= i_wmem_base;
        pbase_q     <= i_pmem_base;
        pass_q      <= '0;
        step_q      <= '0;
      end
      if (state_q == LOAD_W) wmem_addr_q <= wmem_now;
      if (state_q == COMPUTE && !stall) begin
        if (step_end) begin
          step_q <= '0;
          if (!pass_end) pass_q <= pass_q + PASS_WIDTH'(1);
        end else begin
          step_q <= step_q + 3'd1;
        end
      end
    end
  end

  // next state and Moore outputs
  always_comb begin
    state_d            = state_q;
    o_busy             = (state_q != IDLE);
    o_done             = 1'b0;
    tile.wmem_rd_addr  = wmem_addr_q;
    tile.update_wgt    = 1'b0;
    tile.update_bias   = 1'b0;
    tile.bias_sel      = 1'b0;
    tile.wgt_shift     = '0;
    tile.pmem_wr_en    = 1'b0;
    tile.pmem_wr_addr0 = '0;
    tile.pmem_wr_addr1 = '0;
    tile.pmem_rd_addr0 = '0;
    tile.pmem_rd_addr1 = '0;
    unique case (state_q)
      IDLE: begin
        if (i_start) state_d = LOAD_W;
      end
      LOAD_W: begin
        tile.wmem_rd_addr = wmem_now;
        tile.update_bias  = (pass_q == '0);
        state_d           = LATCH_W;
      end
      LATCH_W: begin
        tile.update_wgt = 1'b1;
        state_d         = COMPUTE;
      end
      COMPUTE: begin
        tile.wgt_shift     = step_q;
        tile.pmem_wr_en    = !stall;
        tile.pmem_wr_addr0 = addr0;
        tile.pmem_wr_addr1 = addr1;
        tile.pmem_rd_addr0 = addr0;
        tile.pmem_rd_addr1 = addr1;
        tile.bias_sel      = (pass_q != '0);
        if (!stall && step_end)
          state_d = pass_end ? DONE : LOAD_W;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: directed bench for pe_seq_ctrl.
// Define PE_SEQ_STALL_EN to also exercise the stall input.
module tb_pe_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [1:0] i_mode = '0;
  logic [7:0] i_num_pass = '0;
  logic [6:0] i_wmem_base = '0;
  logic [7:0] i_pmem_base = '0;
  logic       o_busy;
  logic       o_done;
`ifdef PE_SEQ_STALL_EN
  logic       i_stall = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int n_done;

  logic [7:0] wr0_q[$];
  logic [7:0] wr1_q[$];
  logic [6:0] wm_q[$];

  logic [7:0] e1_a0 [8] = '{8'h10, 8'h12, 8'h14, 8'h16,
                            8'h10, 8'h12, 8'h14, 8'h16};
  logic [7:0] e3_a0 [6] = '{8'hFC, 8'hFE, 8'h00, 8'h02, 8'h04, 8'h06};
  logic [7:0] e3_a1 [6] = '{8'hFD, 8'hFF, 8'h01, 8'h03, 8'h05, 8'h07};

  pe_seq_ctrl_if #(.PMEM_ADDR_WIDTH(8), .WMEM_ADDR_WIDTH(7)) tile ();

  pe_seq_ctrl #(
    .PMEM_ADDR_WIDTH(8),
    .WMEM_ADDR_WIDTH(7),
    .PASS_WIDTH(8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
`ifdef PE_SEQ_STALL_EN
    .i_stall     (i_stall),
`endif
    .i_start     (i_start),
    .i_mode      (i_mode),
    .i_num_pass  (i_num_pass),
    .i_wmem_base (i_wmem_base),
    .i_pmem_base (i_pmem_base),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .tile        (tile.master)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_wren"}, tile.pmem_wr_en, 0);
    check({tag, "_shift"}, tile.wgt_shift, 0);
    check({tag, "_a0"}, tile.pmem_wr_addr0, 0);
    check({tag, "_uw"}, tile.update_wgt, 0);
    check({tag, "_ub"}, tile.update_bias, 0);
  endtask

  // One job; expectations come from the cycle timeline:
  // cycle c (1-based after the start edge), k=c-1,
  // pass=k/(S+2), r=k%(S+2): r0 LOAD, r1 LATCH, r>=2 step r-2.
  task automatic run_job(input logic [1:0] md, input logic [7:0] np,
                         input logic [6:0] wb, input logic [7:0] pb,
                         input bit poke, output int done_cyc);
    int s, p, last, k, pi, r, st;
    s    = int'(md) + 3;
    p    = (np == 0) ? 1 : int'(np);
    last = 1 + p * (s + 2);
    wr0_q.delete();
    wr1_q.delete();
    wm_q.delete();
    n_done   = 0;
    done_cyc = -1;
    @(negedge i_clk);
    i_mode = md; i_num_pass = np;
    i_wmem_base = wb; i_pmem_base = pb;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_mode = ~md; i_num_pass = np + 8'd3;
    i_wmem_base = wb + 7'd9; i_pmem_base = pb + 8'h40;
    for (int c = 1; c <= last + 2; c++) begin
      if (o_done) begin
        n_done++;
        done_cyc = c;
      end
      if (tile.pmem_wr_en) begin
        wr0_q.push_back(tile.pmem_wr_addr0);
        wr1_q.push_back(tile.pmem_wr_addr1);
      end
      if (tile.update_wgt) wm_q.push_back(tile.wmem_rd_addr);
      if (c < last) begin
        k  = c - 1;
        pi = k / (s + 2);
        r  = k % (s + 2);
        st = (r >= 2) ? r - 2 : 0;
        check("busy", o_busy, 1);
        check("done", o_done, 0);
        check("ub", tile.update_bias, (r == 0 && pi == 0) ? 1 : 0);
        check("uw", tile.update_wgt, (r == 1) ? 1 : 0);
        check("wren", tile.pmem_wr_en, (r >= 2) ? 1 : 0);
        check("shift", tile.wgt_shift, st);
        check("bsel", tile.bias_sel, (r >= 2 && pi != 0) ? 1 : 0);
        check("wa0", tile.pmem_wr_addr0,
              (r >= 2) ? 32'((pb + 2 * st) & 8'hFF) : 0);
        check("wa1", tile.pmem_wr_addr1,
              (r >= 2) ? 32'((pb + 2 * st + 1) & 8'hFF) : 0);
        check("ra0", tile.pmem_rd_addr0, tile.pmem_wr_addr0);
        check("ra1", tile.pmem_rd_addr1, tile.pmem_wr_addr1);
        if (r <= 1)
          check("wmaddr", tile.wmem_rd_addr, 32'((wb + pi) & 7'h7F));
      end else if (c == last) begin
        check("busy_dn", o_busy, 1);
        check("done_dn", o_done, 1);
        check("wren_dn", tile.pmem_wr_en, 0);
        check("shift_dn", tile.wgt_shift, 0);
      end else begin
        check_idle("post");
      end
      i_start = (poke && (c == 2 || c == last)) ? 1'b1 : 1'b0;
      @(negedge i_clk);
    end
    i_start = 1'b0;
    check("ndone", n_done, 1);
  endtask

  initial begin
    int dc;
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    check_idle("rst");
    check("rst_wm", tile.wmem_rd_addr, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_idle("rst_rel");

    // mode 01, 2 passes
    run_job(2'b01, 8'd2, 7'd5, 8'h10, 1'b0, dc);
    check("t1_done_cyc", dc, 13);
    check("t1_nwr", wr0_q.size(), 8);
    for (int i = 0; i < 8 && i < wr0_q.size(); i++)
      check("t1_a0", wr0_q[i], e1_a0[i]);
    check("t1_nwm", wm_q.size(), 2);
    if (wm_q.size() == 2) begin
      check("t1_wm0", wm_q[0], 5);
      check("t1_wm1", wm_q[1], 6);
    end

    // num_pass 0 treated as 1
    run_job(2'b00, 8'd0, 7'd0, 8'h00, 1'b0, dc);
    check("t2_done_cyc", dc, 6);
    check("t2_nwr", wr0_q.size(), 3);

    // mode 11 with wrap, plus start pokes while busy / in DONE
    run_job(2'b11, 8'd1, 7'h7F, 8'hFC, 1'b1, dc);
    check("t3_done_cyc", dc, 9);
    check("t3_nwr", wr0_q.size(), 6);
    for (int i = 0; i < 6 && i < wr0_q.size(); i++) begin
      check("t3_a0", wr0_q[i], e3_a0[i]);
      check("t3_a1", wr1_q[i], e3_a1[i]);
    end

    // wmem address wraps across passes
    run_job(2'b10, 8'd3, 7'h7E, 8'h80, 1'b0, dc);
    check("t4_done_cyc", dc, 22);
    if (wm_q.size() == 3) check("t4_wm2", wm_q[2], 0);
    else check("t4_nwm", wm_q.size(), 3);

    // asynchronous reset mid-COMPUTE
    @(negedge i_clk);
    i_mode = 2'b11; i_num_pass = 8'd2;
    i_wmem_base = 7'd3; i_pmem_base = 8'h20;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    check("ar_pre_wren", tile.pmem_wr_en, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check_idle("ar");
    check("ar_wm", tile.wmem_rd_addr, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (o_done) n_done++;
      if (o_busy) check("ar_busy", o_busy, 0);
      @(negedge i_clk);
    end
    check("ar_nodone", n_done, 0);
    check_idle("ar_end");

`ifdef PE_SEQ_STALL_EN
    // mode 10, stall 2 cycles at step 2
    begin
      logic [2:0] e_sh [11] = '{0, 0, 0, 0, 1, 2, 2, 2, 3, 4, 0};
      logic       e_we [11] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0};
      @(negedge i_clk);
      i_mode = 2'b10; i_num_pass = 8'd1;
      i_wmem_base = 7'd0; i_pmem_base = 8'h00;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        i_stall = (c == 5 || c == 6);
        #1;
        check("st_shift", tile.wgt_shift, e_sh[c]);
        check("st_wren", tile.pmem_wr_en, e_we[c]);
        check("st_done", o_done, (c == 10) ? 1 : 0);
        @(negedge i_clk);
      end
      i_stall = 1'b0;
      check("st_busy_end", o_busy, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
